// File: rtl/startup_pkg.sv
// Shared types and widths for the startup sequencer (startup_seq).
package startup_pkg;

  localparam int CNT_W = 16;
  localparam int LCK_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    ROC       = 2'd1,
    TOC       = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/startup_seq_sync2.sv
// Two-flop synchronizer, cleared by the asynchronous reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/startup_seq.sv
// Power-up sequencer: qualifies PLL lock, then releases GSR/PRLD, GTS and raises done.
// Optional macro STARTUP_LOCK_MON_EN: a lock loss in DONE restarts the sequence.
module startup_seq
  import startup_pkg::*;
#(
  parameter int ROC_CYCLES  = 100,
  parameter int TOC_CYCLES  = 0,
  parameter int LOCK_FILTER = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic restart,
  output logic gsr,
  output logic prld,
  output logic gts,
  output logic done
);

  localparam logic [CNT_W-1:0] ROC_LOAD   = CNT_W'(ROC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOC_LOAD   = (TOC_CYCLES > 0) ? CNT_W'(TOC_CYCLES - 1) : '0;
  localparam logic [LCK_W-1:0] LCK_TARGET = LCK_W'(LOCK_FILTER);

  logic lock_s;

  sync2 u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [LCK_W-1:0]   lock_cnt_reg, lock_cnt_next, lock_cnt_inc;
  logic               gsr_reg, gts_reg, done_reg;

  assign lock_cnt_inc = (lock_cnt_reg == '1) ? lock_cnt_reg : lock_cnt_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    lock_cnt_next = lock_cnt_reg;
    if (restart) begin
      state_next    = WAIT_LOCK;
      cnt_next      = '0;
      lock_cnt_next = '0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (!lock_s) begin
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = lock_cnt_inc;
            if (lock_cnt_inc >= LCK_TARGET) begin
              state_next = ROC;
              cnt_next   = ROC_LOAD;
            end
          end
        end
        ROC: begin
          if (!lock_s) begin
            state_next    = WAIT_LOCK;
            cnt_next      = '0;
            lock_cnt_next = '0;
          end else if (cnt_reg == '0) begin
            if (TOC_CYCLES > 0) begin
              state_next = TOC;
              cnt_next   = TOC_LOAD;
            end else begin
              state_next = DONE;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        TOC: begin
          if (!lock_s) begin
            state_next    = WAIT_LOCK;
            cnt_next      = '0;
            lock_cnt_next = '0;
          end else if (cnt_reg == '0) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        DONE: begin
`ifdef STARTUP_LOCK_MON_EN
          if (!lock_s) begin
            state_next    = WAIT_LOCK;
            cnt_next      = '0;
            lock_cnt_next = '0;
          end
`endif
        end
        default: begin
          state_next    = WAIT_LOCK;
          cnt_next      = '0;
          lock_cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= WAIT_LOCK;
      cnt_reg      <= '0;
      lock_cnt_reg <= '0;
      gsr_reg      <= 1'b1;
      gts_reg      <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      lock_cnt_reg <= lock_cnt_next;
      gsr_reg      <= (state_next == WAIT_LOCK) || (state_next == ROC);
      gts_reg      <= (state_next != DONE);
      done_reg     <= (state_next == DONE);
    end
  end

  assign gsr  = gsr_reg;
  assign prld = gsr_reg;
  assign gts  = gts_reg;
  assign done = done_reg;

endmodule
